// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath defaults, ALU operation codes and
// the operand forwarding-select encoding used by the execute stage.
package pipe_pkg;

    // Default datapath and register-index widths
    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    // ALUctr encodings
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_LUI  = 3'b111;

    // Operand source selected by the forwarding logic
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

endpackage

// File: rtl/ex_stage_alu32.sv
// alu32: purely combinational 8-operation ALU. Signed overflow is always
// computed for ADD/SUB; the enclosing stage decides whether it is used.
module alu32
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [2:0]    ALUctr,
    input  logic [15:0]   imm16,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          ovf
);

    logic [DW-1:0] sum;
    logic [DW-1:0] diff;
    logic          slt_s;
    logic          slt_u;

    // Operation select, overflow detection and zero flag
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // held over from the previous evaluation, which would infer a latch.
        result = '0;
        ovf    = 1'b0;
        sum    = A + B;
        diff   = A - B;
        slt_s  = $signed(A) < $signed(B);
        slt_u  = A < B;
        case (ALUctr)
            ALU_ADD: begin
                result = sum;
                ovf    = (A[DW-1] == B[DW-1]) && (sum[DW-1] != A[DW-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (A[DW-1] != B[DW-1]) && (diff[DW-1] != A[DW-1]);
            end
            ALU_AND:  result = A & B;
            ALU_OR:   result = A | B;
            ALU_SLT:  result = {{(DW-1){1'b0}}, slt_s};
            ALU_SLTU: result = {{(DW-1){1'b0}}, slt_u};
            ALU_XOR:  result = A ^ B;
            ALU_LUI:  result = {imm16, {(DW-16){1'b0}}};
            default:  result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Extends the immediate, forwards operands from the
// EX/MEM latch and the WB stage, runs the ALU and registers the results into
// the EX/MEM latch on the falling clock edge.
// Build option: define EX_OVF_TRAP_EN to report signed ADD/SUB overflow on
// ovf_out and suppress that instruction's register and memory writes.
module ex_stage
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [15:0]   imm16_in,
    input  logic [DW-1:0] busA_in,
    input  logic [DW-1:0] busB_in,
    input  logic [RW-1:0] Rs_in,
    input  logic [RW-1:0] Rt_in,
    input  logic [RW-1:0] Rd_in,
    input  logic          Extop_in,
    input  logic          ALUSrc_in,
    input  logic [2:0]    ALUctr_in,
    input  logic          MemtoReg_in,
    input  logic          MemWr_in,
    input  logic          RegWr_in,
    input  logic          RegDst_in,
    input  logic          wb_RegWr,
    input  logic [RW-1:0] wb_Rw,
    input  logic [DW-1:0] wb_busW,
    output logic [DW-1:0] alu_out,
    output logic [DW-1:0] busB_out,
    output logic [RW-1:0] Rw_out,
    output logic          MemtoReg_out,
    output logic          MemWr_out,
    output logic          RegWr_out,
    output logic          zero_out,
    output logic          ovf_out,
    output logic          ld_use_stall
);

`ifdef EX_OVF_TRAP_EN
    localparam bit OVF_TRAP = 1'b1;
`else
    localparam bit OVF_TRAP = 1'b0;
`endif

    // EX/MEM latch
    logic [DW-1:0] alu_out_q, alu_out_d;
    logic [DW-1:0] busB_out_q, busB_out_d;
    logic [RW-1:0] Rw_out_q, Rw_out_d;
    logic          MemtoReg_out_q, MemtoReg_out_d;
    logic          MemWr_out_q, MemWr_out_d;
    logic          RegWr_out_q, RegWr_out_d;
    logic          zero_out_q, zero_out_d;
    logic          ovf_out_q, ovf_out_d;

    logic [DW-1:0] imm32;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic [DW-1:0] op_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          alu_ovf;
    logic          trap;

    // Immediate extension and forwarding selection for both operands
    always_comb begin
        imm32 = Extop_in ? {{(DW-16){imm16_in[15]}}, imm16_in}
                         : {{(DW-16){1'b0}}, imm16_in};

        // A load in EX/MEM has no data yet; it is left to the stall request.
        fwd_a_sel = FWD_REG;
        if (RegWr_out_q && (Rw_out_q != '0) && (Rw_out_q == Rs_in) && !MemtoReg_out_q)
            fwd_a_sel = FWD_EXMEM;
        else if (wb_RegWr && (wb_Rw != '0) && (wb_Rw == Rs_in))
            fwd_a_sel = FWD_WB;

        fwd_b_sel = FWD_REG;
        if (RegWr_out_q && (Rw_out_q != '0) && (Rw_out_q == Rt_in) && !MemtoReg_out_q)
            fwd_b_sel = FWD_EXMEM;
        else if (wb_RegWr && (wb_Rw != '0) && (wb_Rw == Rt_in))
            fwd_b_sel = FWD_WB;
    end

    // Operand muxes
    always_comb begin
        case (fwd_a_sel)
            FWD_EXMEM: op_a = alu_out_q;
            FWD_WB:    op_a = wb_busW;
            default:   op_a = busA_in;
        endcase
        case (fwd_b_sel)
            FWD_EXMEM: fwd_b = alu_out_q;
            FWD_WB:    fwd_b = wb_busW;
            default:   fwd_b = busB_in;
        endcase
        op_b = ALUSrc_in ? imm32 : fwd_b;
    end

    alu32 #(.DW(DW)) u_alu (
        .A      (op_a),
        .B      (op_b),
        .ALUctr (ALUctr_in),
        .imm16  (imm16_in),
        .result (alu_result),
        .zero   (alu_zero),
        .ovf    (alu_ovf)
    );

    // Next latch contents; a flush loads a bubble
    always_comb begin
        trap           = OVF_TRAP & alu_ovf;
        alu_out_d      = alu_result;
        busB_out_d     = fwd_b;
        Rw_out_d       = RegDst_in ? Rd_in : Rt_in;
        MemtoReg_out_d = MemtoReg_in;
        MemWr_out_d    = MemWr_in & ~trap;
        RegWr_out_d    = RegWr_in & ~trap;
        zero_out_d     = alu_zero;
        ovf_out_d      = trap;
        if (flush) begin
            alu_out_d      = '0;
            busB_out_d     = '0;
            Rw_out_d       = '0;
            MemtoReg_out_d = 1'b0;
            MemWr_out_d    = 1'b0;
            RegWr_out_d    = 1'b0;
            zero_out_d     = 1'b0;
            ovf_out_d      = 1'b0;
        end
    end

    // EX/MEM latch, falling-edge updated with synchronous reset
    always_ff @(negedge clk) begin
        // NOTE: non-blocking assignments so every flop samples its _d value
        // from before this edge, independent of statement order.
        if (rst) begin
            alu_out_q      <= '0;
            busB_out_q     <= '0;
            Rw_out_q       <= '0;
            MemtoReg_out_q <= 1'b0;
            MemWr_out_q    <= 1'b0;
            RegWr_out_q    <= 1'b0;
            zero_out_q     <= 1'b0;
            ovf_out_q      <= 1'b0;
        end else begin
            alu_out_q      <= alu_out_d;
            busB_out_q     <= busB_out_d;
            Rw_out_q       <= Rw_out_d;
            MemtoReg_out_q <= MemtoReg_out_d;
            MemWr_out_q    <= MemWr_out_d;
            RegWr_out_q    <= RegWr_out_d;
            zero_out_q     <= zero_out_d;
            ovf_out_q      <= ovf_out_d;
        end
    end

    // Load-use hazard request and output drive
    always_comb begin
        ld_use_stall = RegWr_out_q & MemtoReg_out_q & (Rw_out_q != '0) &
                       ((Rw_out_q == Rs_in) | (Rw_out_q == Rt_in));
        alu_out      = alu_out_q;
        busB_out     = busB_out_q;
        Rw_out       = Rw_out_q;
        MemtoReg_out = MemtoReg_out_q;
        MemWr_out    = MemWr_out_q;
        RegWr_out    = RegWr_out_q;
        zero_out     = zero_out_q;
        ovf_out      = ovf_out_q;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: reset, extension, forwarding priority,
// load-use stall, flush, ALU operations and overflow handling.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] imm16_in;
    logic [31:0] busA_in, busB_in;
    logic [4:0]  Rs_in, Rt_in, Rd_in;
    logic        Extop_in, ALUSrc_in;
    logic [2:0]  ALUctr_in;
    logic        MemtoReg_in, MemWr_in, RegWr_in, RegDst_in;
    logic        wb_RegWr;
    logic [4:0]  wb_Rw;
    logic [31:0] wb_busW;
    logic [31:0] alu_out, busB_out;
    logic [4:0]  Rw_out;
    logic        MemtoReg_out, MemWr_out, RegWr_out, zero_out, ovf_out, ld_use_stall;

    int n_vec = 0;
    int n_err = 0;

    ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .imm16_in     (imm16_in),
        .busA_in      (busA_in),
        .busB_in      (busB_in),
        .Rs_in        (Rs_in),
        .Rt_in        (Rt_in),
        .Rd_in        (Rd_in),
        .Extop_in     (Extop_in),
        .ALUSrc_in    (ALUSrc_in),
        .ALUctr_in    (ALUctr_in),
        .MemtoReg_in  (MemtoReg_in),
        .MemWr_in     (MemWr_in),
        .RegWr_in     (RegWr_in),
        .RegDst_in    (RegDst_in),
        .wb_RegWr     (wb_RegWr),
        .wb_Rw        (wb_Rw),
        .wb_busW      (wb_busW),
        .alu_out      (alu_out),
        .busB_out     (busB_out),
        .Rw_out       (Rw_out),
        .MemtoReg_out (MemtoReg_out),
        .MemWr_out    (MemWr_out),
        .RegWr_out    (RegWr_out),
        .zero_out     (zero_out),
        .ovf_out      (ovf_out),
        .ld_use_stall (ld_use_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bubble on every ID/EX and WB input
    task automatic clear_in();
        flush = 0; imm16_in = 0; busA_in = 0; busB_in = 0;
        Rs_in = 0; Rt_in = 0; Rd_in = 0; Extop_in = 0; ALUSrc_in = 0;
        ALUctr_in = 0; MemtoReg_in = 0; MemWr_in = 0; RegWr_in = 0; RegDst_in = 0;
        wb_RegWr = 0; wb_Rw = 0; wb_busW = 0;
    endtask

    // Advance past the next active (falling) edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // R-type helper: rd = op(rs, rt) with raw bus values
    task automatic rtype(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        clear_in();
        ALUctr_in = op; Rs_in = rs; Rt_in = rt; Rd_in = rd; RegDst_in = 1;
        busA_in = a; busB_in = b; RegWr_in = 1;
    endtask

    initial begin
        // Reset with random inputs for two edges
        rst = 1;
        clear_in();
        for (int i = 0; i < 2; i++) begin
            imm16_in = 16'($urandom); busA_in = $urandom; busB_in = $urandom;
            Rs_in = 5'($urandom); Rt_in = 5'($urandom); Rd_in = 5'($urandom);
            {Extop_in, ALUSrc_in, MemtoReg_in, MemWr_in, RegWr_in, RegDst_in} = 6'($urandom);
            ALUctr_in = 3'($urandom); flush = 1'($urandom);
            wb_RegWr = 1'($urandom); wb_Rw = 5'($urandom); wb_busW = $urandom;
            tick();
        end
        check("rst_alu", alu_out, 32'h0);
        check("rst_busB", busB_out, 32'h0);
        check("rst_rw", {27'h0, Rw_out}, 32'h0);
        check("rst_ctrl", {26'h0, MemtoReg_out, MemWr_out, RegWr_out, zero_out, ovf_out, ld_use_stall}, 32'h0);
        rst = 0;

        // ADDI with sign extension: 0x10 + 0xFFFFFFFF
        clear_in();
        busA_in = 32'h10; busB_in = 32'h22; imm16_in = 16'hFFFF; Extop_in = 1; ALUSrc_in = 1;
        Rs_in = 1; Rt_in = 5; Rd_in = 9; RegWr_in = 1;
        tick();
        check("addi_sext", alu_out, 32'h0000000F);
        check("addi_rw", {27'h0, Rw_out}, 32'd5);
        check("addi_busB", busB_out, 32'h22);
        check("addi_regwr", {31'h0, RegWr_out}, 32'h1);

        // Same with zero extension
        Extop_in = 0; Rt_in = 6;
        tick();
        check("addi_zext", alu_out, 32'h0001000F);

        // add r3 = r1 + r2, then sub r4 = r3 - r1 with stale busA
        rtype(3'b000, 1, 2, 3, 32'd5, 32'd7);
        tick();
        check("add_r3", alu_out, 32'd12);
        rtype(3'b001, 3, 1, 4, 32'd0, 32'd5);
        tick();
        check("fwd_exmem", alu_out, 32'd7);

        // EX/MEM r3=12 and WB r3=99 both pending: EX/MEM wins
        rtype(3'b000, 1, 2, 3, 32'd5, 32'd7);
        tick();
        rtype(3'b000, 3, 0, 5, 32'd1, 32'd0);
        wb_RegWr = 1; wb_Rw = 3; wb_busW = 32'd99;
        tick();
        check("fwd_prio", alu_out, 32'd12);

        // WB only (EX/MEM now holds r5)
        rtype(3'b000, 3, 0, 6, 32'd1, 32'd0);
        wb_RegWr = 1; wb_Rw = 3; wb_busW = 32'd99;
        tick();
        check("fwd_wb", alu_out, 32'd99);

        // Register 0 is never forwarded
        rtype(3'b000, 10, 11, 0, 32'd12, 32'd0);
        tick();
        rtype(3'b000, 0, 0, 7, 32'h55, 32'h11);
        wb_RegWr = 1; wb_Rw = 0; wb_busW = 32'd99;
        tick();
        check("r0_alu", alu_out, 32'h66);
        check("r0_busB", busB_out, 32'h11);

        // busB_out carries forwarded rt even when ALUSrc=1 (sw r7 -> store data 0x66)
        clear_in();
        Rs_in = 0; Rt_in = 7; busB_in = 32'h1; ALUSrc_in = 1; imm16_in = 16'h8; MemWr_in = 1;
        tick();
        check("sw_busB", busB_out, 32'h66);
        check("sw_alu", alu_out, 32'h8);
        check("sw_memwr", {30'h0, MemWr_out, RegWr_out}, 32'h2);

        // Load r8, then a reader of r8 raises the stall; flush inserts a bubble
        clear_in();
        busA_in = 32'h100; imm16_in = 16'h4; ALUSrc_in = 1; Rt_in = 8;
        MemtoReg_in = 1; RegWr_in = 1;
        tick();
        check("ld_alu", alu_out, 32'h104);
        check("ld_ctrl", {29'h0, MemtoReg_out, RegWr_out, Rw_out == 5'd8}, 32'h7);
        rtype(3'b000, 9, 7, 10, 32'h3, 32'h4);
        #1;
        check("no_stall", {31'h0, ld_use_stall}, 32'h0);
        Rs_in = 8; MemWr_in = 1;
        #1;
        check("stall_rs", {31'h0, ld_use_stall}, 32'h1);
        flush = 1;
        tick();
        check("flush_ctrl", {28'h0, MemtoReg_out, MemWr_out, RegWr_out, ld_use_stall}, 32'h0);
        check("flush_alu", alu_out, 32'h0);

        // A load in EX/MEM is not forwarded; the stall on Rt is raised
        clear_in();
        busA_in = 32'h100; imm16_in = 16'h4; ALUSrc_in = 1; Rt_in = 8;
        MemtoReg_in = 1; RegWr_in = 1;
        tick();
        rtype(3'b000, 9, 8, 10, 32'h3, 32'h4);
        #1;
        check("stall_rt", {31'h0, ld_use_stall}, 32'h1);
        tick();
        check("ld_nofwd", alu_out, 32'h7);

        // Compare, logic and LUI operations
        rtype(3'b100, 12, 13, 14, 32'hFFFFFFFF, 32'h1);
        tick();
        check("slt", alu_out, 32'h1);
        rtype(3'b101, 12, 13, 14, 32'hFFFFFFFF, 32'h1);
        tick();
        check("sltu", alu_out, 32'h0);
        check("sltu_zero", {31'h0, zero_out}, 32'h1);
        rtype(3'b010, 12, 13, 14, 32'hF0F000FF, 32'h0FF00F0F);
        tick();
        check("and", alu_out, 32'h00F0000F);
        rtype(3'b011, 12, 13, 14, 32'hF0F000FF, 32'h0FF00F0F);
        tick();
        check("or", alu_out, 32'hFFF00FFF);
        rtype(3'b110, 12, 13, 14, 32'hF0F000FF, 32'h0FF00F0F);
        tick();
        check("xor", alu_out, 32'hFF000FF0);
        check("xor_zero", {31'h0, zero_out}, 32'h0);
        rtype(3'b111, 12, 13, 14, 32'h0, 32'h0);
        imm16_in = 16'hABCD; ALUSrc_in = 1;
        tick();
        check("lui", alu_out, 32'hABCD0000);

        // Signed overflow on ADD and SUB
        rtype(3'b000, 12, 13, 15, 32'h7FFFFFFF, 32'h1);
        MemWr_in = 1;
        tick();
        check("ovf_add_alu", alu_out, 32'h80000000);
`ifdef EX_OVF_TRAP_EN
        check("ovf_add_flags", {29'h0, ovf_out, RegWr_out, MemWr_out}, 32'h4);
`else
        check("ovf_add_flags", {29'h0, ovf_out, RegWr_out, MemWr_out}, 32'h3);
`endif
        rtype(3'b001, 12, 13, 16, 32'h80000000, 32'h1);
        tick();
        check("ovf_sub_alu", alu_out, 32'h7FFFFFFF);
`ifdef EX_OVF_TRAP_EN
        check("ovf_sub_flags", {30'h0, ovf_out, RegWr_out}, 32'h2);
`else
        check("ovf_sub_flags", {30'h0, ovf_out, RegWr_out}, 32'h1);
`endif
        rtype(3'b000, 12, 13, 17, 32'hFFFFFFFF, 32'h1);
        tick();
        check("noovf_add", {30'h0, ovf_out, RegWr_out}, 32'h1);
        check("noovf_zero", {31'h0, zero_out}, 32'h1);

        // All-zero bubble has no architectural effect
        clear_in();
        tick();
        check("bubble", {30'h0, RegWr_out, MemWr_out}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
